// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit feeding a DEPTH-entry FIFO for decode.
// Optional halt-on-opcode-F behaviour is enabled by defining FETCH_HALT_EN.
//
// Ports:
//   clk           - sole clock, rising edge
//   reset         - asynchronous reset, active low
//   mem_req       - instruction memory read request (FETCH state only)
//   mem_addr      - fetch PC, stable while mem_req=1
//   mem_valid     - read data valid for mem_addr, sampled only with mem_req=1
//   mem_rdata     - instruction word {opcode[7:4], operand[3:0]}
//   instr_valid   - queue head holds a valid instruction
//   instr_ready   - decode accepts the head entry
//   instr_opcode  - head opcode
//   instr_operand - head operand
//   instr_pc      - address the head instruction was fetched from
//   redirect      - flush queue and restart fetch at redirect_addr
//   redirect_addr - new fetch address
//   halted        - fetch stopped by a halt opcode (0 without FETCH_HALT_EN)

module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       mem_req,
    output logic [3:0] mem_addr,
    input  logic       mem_valid,
    input  logic [7:0] mem_rdata,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [3:0] instr_opcode,
    output logic [3:0] instr_operand,
    output logic [3:0] instr_pc,
    input  logic       redirect,
    input  logic [3:0] redirect_addr,
    output logic       halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [PW-1:0] ONE_P = PW'(1);

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        WAIT_SPACE = 2'd1
`ifdef FETCH_HALT_EN
        ,
        HALT       = 2'd2
`endif
    } state_t;

    state_t state;
    state_t state_n;

    logic [3:0]    pc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_nxt;

    // Entry layout: {pc[11:8], opcode[7:4], operand[3:0]}
    logic [11:0] q [DEPTH];
    logic [11:0] head;
    logic [11:0] new_entry;

    logic push;
    logic pop;

    // Gated by reset so no request is visible while reset is held.
    assign mem_req     = reset && (state == FETCH);
    assign mem_addr    = pc;
    assign instr_valid = (count != '0);

    assign push      = mem_req && mem_valid && !redirect;
    assign pop       = instr_valid && instr_ready;
    assign rd_nxt    = rd_ptr + ONE_P;
    assign new_entry = {pc, mem_rdata};

    assign instr_pc      = head[11:8];
    assign instr_opcode  = head[7:4];
    assign instr_operand = head[3:0];

`ifdef FETCH_HALT_EN
    logic halt_op;
    assign halt_op = (mem_rdata[7:4] == 4'hF);
    assign halted  = (state == HALT);
`else
    assign halted  = 1'b0;
`endif

    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + ONE_C;
        end else if (!push && pop) begin
            count_n = count - ONE_C;
        end
    end

    // FETCH is only ever entered with count < DEPTH, so a push never
    // overflows and no response is ever dropped.
    always_comb begin
        state_n = state;
        if (redirect) begin
            state_n = FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    if (push) begin
                        if (count_n == FULL) begin
                            state_n = WAIT_SPACE;
                        end
`ifdef FETCH_HALT_EN
                        if (halt_op) begin
                            state_n = HALT;
                        end
`endif
                    end
                end
                WAIT_SPACE: begin
                    if (count_n < FULL) begin
                        state_n = FETCH;
                    end
                end
`ifdef FETCH_HALT_EN
                HALT: begin
                    state_n = HALT;
                end
`endif
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= 4'd0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            head   <= 12'd0;
        end else begin
            state <= state_n;
            if (redirect) begin
                pc     <= redirect_addr;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_n;
                if (push) begin
                    pc     <= pc + 4'd1;
                    wr_ptr <= wr_ptr + ONE_P;
                end
                if (pop) begin
                    rd_ptr <= rd_nxt;
                end
                // Head register tracks the entry at the read pointer after
                // this edge; a push into an (about to be) empty queue goes
                // straight to the head for single-cycle latency.
                if (push && (count == '0 ||
                             (count == ONE_C && pop))) begin
                    head <= new_entry;
                end else if (pop && count > ONE_C) begin
                    head <= q[rd_nxt];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q[wr_ptr] <= new_entry;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue.
// Driver models memory and the expected stream; monitor checks the head.

module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic       mem_valid;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_opcode;
    logic [3:0] instr_operand;
    logic [3:0] instr_pc;
    logic       redirect;
    logic [3:0] redirect_addr;
    logic       halted;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_operand(instr_operand),
        .instr_pc     (instr_pc),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .halted       (halted)
    );

    logic [7:0] memv [16];
    assign mem_rdata = memv[mem_addr];

    typedef struct packed {
        logic [3:0] pc;
        logic [7:0] word;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int p_valid = 100;
    int p_ready = 100;
    int p_redir = 0;
    bit rst_req = 1'b0;
    bit run = 1'b1;

    logic [3:0] pc_m;
    bit         halt_m;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 16'(instr_valid), 16'd0);
        chk({tag, "_req"}, 16'(mem_req), 16'd0);
        chk({tag, "_halted"}, 16'(halted), 16'd0);
        chk({tag, "_head"}, {4'd0, instr_pc, instr_opcode, instr_operand},
            16'd0);
    endtask

    // Driver + reference model: the expected stream is simply consecutive
    // PCs from the last restart point, each carrying memory[pc].
    initial begin : driver
        bit fetch_m;
        bit push_now;
        pc_m          = 4'd0;
        halt_m        = 1'b0;
        reset         = 1'b0;
        mem_valid     = 1'b0;
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 4'd0;
        @(negedge clk);
        chk_zero("rst");
        reset = 1'b1;
        #1;
        chk("rel_req", 16'(mem_req), 16'd1);
        chk("rel_addr", 16'(mem_addr), 16'd0);
        while (run) begin
            @(negedge clk);
            if (rst_req) begin
                reset     = 1'b0;
                mem_valid = 1'b0;
                redirect  = 1'b0;
                #1;
                chk_zero("midrst");
                exp_q.delete();
                pc_m    = 4'd0;
                halt_m  = 1'b0;
                rst_req = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                #1;
                chk("mid_req", 16'(mem_req), 16'd1);
                chk("mid_addr", 16'(mem_addr), 16'd0);
                continue;
            end
            mem_valid     = ($urandom_range(99) < p_valid);
            instr_ready   = ($urandom_range(99) < p_ready);
            redirect      = ($urandom_range(99) < p_redir);
            redirect_addr = 4'($urandom);
            fetch_m = (exp_q.size() < DEPTH) && !halt_m;
            chk("mem_req", 16'(mem_req), 16'(fetch_m));
            chk("halted", 16'(halted), 16'(halt_m));
            if (fetch_m) begin
                chk("mem_addr", 16'(mem_addr), 16'(pc_m));
            end
            push_now = fetch_m && mem_valid && !redirect;
            @(posedge clk);
            if (redirect) begin
                exp_q.delete();
                pc_m   = redirect_addr;
                halt_m = 1'b0;
            end else if (push_now) begin
                exp_q.push_back({pc_m, memv[pc_m]});
`ifdef FETCH_HALT_EN
                if (memv[pc_m][7:4] == 4'hF) begin
                    halt_m = 1'b1;
                end
`endif
                pc_m = pc_m + 4'd1;
            end
        end
    end

    // Monitor: compares each handshake against the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b1) begin
                chk("instr_valid", 16'(instr_valid),
                    16'(exp_q.size() != 0));
                if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=pc%0h required=none",
                                 instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("head_pc", 16'(instr_pc), 16'(e.pc));
                        chk("head_word", 16'({instr_opcode, instr_operand}),
                            16'(e.word));
                    end
                end
            end
        end
    end

    initial begin : main
        for (int a = 0; a < 16; a++) begin
            memv[a] = 8'(a) + 8'h20;
        end
        // Streaming at full rate, covers PC wrap 15 -> 0.
        repeat (40) @(negedge clk);
        // Fill with decode stalled from a fresh reset.
        p_ready = 0;
        rst_req = 1'b1;
        repeat (12) @(negedge clk);
        #3;
        chk("stall_req", 16'(mem_req), 16'd0);
        chk("stall_addr", 16'(mem_addr), 16'd4);
        chk("stall_head", 16'(instr_pc), 16'd0);
        p_ready = 100;
        repeat (12) @(negedge clk);
        // Random traffic with redirects and random memory contents.
        for (int a = 0; a < 16; a++) begin
            memv[a] = 8'($urandom);
        end
        p_valid = 60;
        p_ready = 60;
        p_redir = 8;
        repeat (2000) @(negedge clk);
        p_redir = 0;
        p_ready = 30;
        repeat (30) @(negedge clk);
        rst_req = 1'b1;
        repeat (300) @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of 2, range 2..8).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 mem_req  output  1  instruction-memory read request.
REQ-005 mem_addr  output  4  instruction address, held stable while mem_req=1.
REQ-006 mem_valid  input  1  read data valid for current mem_addr; sampled only when mem_req=1.
REQ-007 mem_rdata  input  8  instruction word {opcode[7:4], operand[3:0]}.
REQ-008 instr_valid  output  1  queue head holds a valid instruction.
REQ-009 instr_ready  input  1  decode stage accepts head; transfer when instr_valid & instr_ready.
REQ-010 instr_opcode  output  4  head opcode.
REQ-011 instr_operand  output  4  head operand.
REQ-012 instr_pc  output  4  address the head instruction was fetched from.
REQ-013 redirect  input  1  jump/flush request.
REQ-014 redirect_addr  input  4  new fetch address.
REQ-015 halted  output  1  fetch stopped by halt opcode.

Function
REQ-016 States SHALL be FETCH (mem_req=1), WAIT_SPACE (mem_req=0), HALT (mem_req=0, present only with FETCH_HALT_EN).
REQ-017 mem_addr SHALL equal the internal fetch PC; at most one request outstanding; no combinational path from mem_valid to mem_req.
REQ-018 In FETCH with mem_valid=1 and no redirect: push {fetch PC, mem_rdata} at tail, fetch PC += 1 mod 16 (15 wraps to 0).
REQ-019 After a push, next state SHALL be WAIT_SPACE if post-update count == DEPTH, else FETCH; WAIT_SPACE -> FETCH when count < DEPTH.
REQ-020 A response SHALL never be dropped for lack of space; FETCH is entered only with count < DEPTH.
REQ-021 instr_valid = (count != 0); instr_opcode/operand/pc SHALL be registered head-entry fields, order strictly FIFO.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; pop on a full queue and push in the same cycle are both legal.
REQ-023 Latency: request issued in cycle N with mem_valid=1 SHALL produce instr_valid=1 in cycle N+1 if the queue was empty.
REQ-024 redirect=1 SHALL at the next edge set count=0, fetch PC=redirect_addr, state FETCH, halted=0; any same-cycle mem_valid data SHALL be discarded.
REQ-025 redirect with a same-cycle pop: the handshake completes for the consumer; the queue is still flushed to empty.
REQ-026 redirect has priority over push, pop, and HALT.
REQ-027 While count=0, instr_valid SHALL stay 0 regardless of instr_ready.

Reset
REQ-028 With reset=0, asynchronously: fetch PC=0, count=0, read/write pointers=0, state FETCH, halted=0, instr_valid=0, instr_opcode=0, instr_operand=0, instr_pc=0.
REQ-029 mem_req SHALL be 0 while reset=0 and SHALL be 1 in the first cycle after release.
REQ-030 Reset mid-operation SHALL discard all queued entries and any outstanding request.

Configuration
REQ-031 Macro FETCH_HALT_EN defined: a pushed word with opcode 4'b1111 is queued normally, then the state goes to HALT, mem_req=0, and halted=1 until redirect or reset.
REQ-032 FETCH_HALT_EN undefined: opcode 4'b1111 is an ordinary instruction, HALT state is absent, and halted is tied to 0.

Verification
REQ-033 Release reset, mem_valid=1, instr_ready=1, memory[a]=a+8'h20 -> instr_pc 0,1,2,... one per cycle from cycle 2, with instr_opcode=2 and instr_operand=pc.
REQ-034 instr_ready=0, mem_valid=1, DEPTH=4 -> 4 pushes, then mem_req=0 and mem_addr=4; raise instr_ready -> pcs 0..3 out in order, and fetch resumes at 4.
REQ-035 Fetch PC reaches 15 -> the next fetched instr_pc is 0 (wrap).
REQ-036 Queue holds 3 entries; redirect=1 with redirect_addr=9 and mem_valid=1 -> the next cycle has instr_valid=0 and mem_addr=9, the same-cycle data is never output, and the next output is instr_pc=9.
REQ-037 FETCH_HALT_EN, memory[2]=8'hF0 -> pcs 0,1,2 delivered, halted=1, mem_req=0; redirect to 5 -> halted=0 and fetch resumes at 5.
REQ-038 reset=0 asserted mid-stream with 2 entries queued -> outputs immediately zero, and after release fetch restarts at mem_addr=0.
